pla_vector_driver: RTL and testbench

Exhaustive stimulus driver and response compactor for the 12-input, single-output PLA benchmark functions in this suite. On `start` it walks every input minterm 0…2^N_IN−1 onto the `x` bus feeding the function under test, samples the returned `y` bit after a fixed pipeline latency, and accumulates an onset count and a 16-bit MISR signature. Verification uses these two values to prove that an optimized netlist matches its original PLA on the full truth table.

---
 rtl/pla_vector_driver_if.sv | 27 ++
 rtl/pla_vector_driver.sv | 137 +++++++++++++
 tb/tb_pla_vector_driver.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pla_vector_driver_if.sv
// Stimulus/response bus between the exhaustive PLA sweep driver and the
// function under test, plus the compacted result outputs.
interface pla_vector_driver_if #(
    parameter int N_IN = 12
);
    logic            start;
    logic            hold;
    logic [N_IN-1:0] x;
    logic            x_valid;
    logic            y_in;
    logic            busy;
    logic            done;
    logic [N_IN:0]   onset_count;
    logic [15:0]     signature;

    // Driver side: issues vectors, samples y_in, reports results.
    modport master (
        input  start, hold, y_in,
        output x, x_valid, busy, done, onset_count, signature
    );

    // Controller / function-under-test side.
    modport slave (
        output start, hold, y_in,
        input  x, x_valid, busy, done, onset_count, signature
    );
endinterface

// File: rtl/pla_vector_driver.sv
// Walks every N_IN-bit minterm onto x, samples y_in LAT cycles later and
// compacts the responses into an onset count and a 16-bit MISR signature.
module pla_vector_driver #(
    parameter int N_IN = 12,
    parameter int LAT  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    pla_vector_driver_if.master bus
);
    localparam int SRW = (LAT > 0) ? LAT : 1;
    localparam logic [N_IN:0] LAST_CNT = {1'b1, {N_IN{1'b0}}};
    localparam logic [N_IN:0] ONE_CNT  = {{N_IN{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [N_IN:0]   cnt_r;
    logic [N_IN:0]   issue_vec_s;
    logic [N_IN-1:0] x_r;
    logic            x_valid_r;
    logic [SRW-1:0]  sr_r, sr_nxt_s;
    logic            busy_r, done_r;
    logic [N_IN:0]   onset_r;
    logic [15:0]     sig_r;
    logic            issue_s, clear_s, sample_s;

    // MISR step, feedback polynomial x^16+x^5+x^3+x^2+1.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic y);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h002D : 16'h0000) ^ {15'b0, y};
    endfunction

    // Valid tracking: tail of the LAT-deep pipe (or x_valid itself) marks a sample.
    always_comb begin
        sr_nxt_s = (sr_r << 1) | SRW'(x_valid_r);
        if (LAT == 0) begin
            sample_s = x_valid_r;
        end else begin
            sample_s = sr_r[SRW-1];
        end
    end

    // Next-state and issue decision; cnt_r == LAST_CNT means every vector is out.
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        clear_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s = RUN;
                    issue_s     = 1'b1;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = (LAT == 0) ? DONE : DRAIN;
                end else if (!bus.hold) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            DRAIN: begin
                if (sr_nxt_s == '0) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
        issue_vec_s = clear_s ? '0 : cnt_r;
    end

    // Sequencer registers: state, vector counter, x/x_valid, valid pipe, flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            x_r       <= '0;
            x_valid_r <= 1'b0;
            sr_r      <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            x_valid_r <= issue_s;
            sr_r      <= sr_nxt_s;
            busy_r    <= (state_nxt_s == RUN) || (state_nxt_s == DRAIN);
            done_r    <= (state_nxt_s == DONE);
            if (issue_s) begin
                x_r   <= issue_vec_s[N_IN-1:0];
                cnt_r <= issue_vec_s + ONE_CNT;
            end else if (state_nxt_s == IDLE) begin
                x_r   <= '0;
                cnt_r <= cnt_r;
            end else begin
                x_r   <= x_r;
                cnt_r <= cnt_r;
            end
        end
    end

    // Response compaction; results hold after a sweep until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onset_r <= '0;
            sig_r   <= 16'h0000;
        end else if (clear_s) begin
            onset_r <= '0;
            sig_r   <= 16'h0000;
        end else if (sample_s) begin
            onset_r <= onset_r + {{N_IN{1'b0}}, bus.y_in};
            sig_r   <= misr_step(sig_r, bus.y_in);
        end else begin
            onset_r <= onset_r;
            sig_r   <= sig_r;
        end
    end

    assign bus.x           = x_r;
    assign bus.x_valid     = x_valid_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.onset_count = onset_r;
    assign bus.signature   = sig_r;
endmodule

// File: tb/tb_pla_vector_driver.sv
// Scoreboard bench for pla_vector_driver: three instances (LAT 0, 3, 2)
// driven one at a time, with a negedge monitor checking results and x order.
module tb_pla_vector_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic hold = 1'b0;
    int   sel = 0;
    int   fn_sel = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic fval(input int fn, input logic [11:0] v);
        case (fn)
            0: return 1'b0;
            1: return v[0];
            2: return 1'b1;
            3: return (v[11:8] == 4'hF);
            default: return 1'b0;
        endcase
    endfunction

    pla_vector_driver_if #(.N_IN(12)) if0 ();
    pla_vector_driver_if #(.N_IN(12)) if1 ();
    pla_vector_driver_if #(.N_IN(12)) if2 ();

    pla_vector_driver #(.N_IN(12), .LAT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
    pla_vector_driver #(.N_IN(12), .LAT(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
    pla_vector_driver #(.N_IN(12), .LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));

    logic [2:0] p3;
    logic [1:0] p2;
    always_ff @(posedge clk) begin
        p3 <= {p3[1:0], fval(3, if1.x)};
        p2 <= {p2[0], fval(1, if2.x)};
    end

    assign if0.start = (sel == 0) ? start : 1'b0;
    assign if1.start = (sel == 1) ? start : 1'b0;
    assign if2.start = (sel == 2) ? start : 1'b0;
    assign if0.hold  = (sel == 0) ? hold : 1'b0;
    assign if1.hold  = (sel == 1) ? hold : 1'b0;
    assign if2.hold  = (sel == 2) ? hold : 1'b0;
    assign if0.y_in  = fval(fn_sel, if0.x);
    assign if1.y_in  = p3[2];
    assign if2.y_in  = p2[1];

    logic [11:0] m_x;
    logic        m_xv, m_busy, m_done;
    logic [12:0] m_onset;
    logic [15:0] m_sig;
    always_comb begin
        case (sel)
            1: begin m_x = if1.x; m_xv = if1.x_valid; m_busy = if1.busy; m_done = if1.done; m_onset = if1.onset_count; m_sig = if1.signature; end
            2: begin m_x = if2.x; m_xv = if2.x_valid; m_busy = if2.busy; m_done = if2.done; m_onset = if2.onset_count; m_sig = if2.signature; end
            default: begin m_x = if0.x; m_xv = if0.x_valid; m_busy = if0.busy; m_done = if0.done; m_onset = if0.onset_count; m_sig = if0.signature; end
        endcase
    end

    typedef struct {
        int          done_cyc;
        logic [12:0] onset;
        logic [15:0] sig;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference compactor written per tap: x^16+x^5+x^3+x^2+1.
    task automatic model(input int fn, output logic [12:0] on, output logic [15:0] sg);
        logic [15:0] s, n;
        logic fb, y;
        s = 16'h0000;
        on = 13'd0;
        for (int v = 0; v < 4096; v++) begin
            y = fval(fn, v[11:0]);
            fb = s[15];
            for (int b = 1; b < 16; b++) n[b] = s[b-1];
            n[0] = fb ^ y;
            n[2] = n[2] ^ fb;
            n[3] = n[3] ^ fb;
            n[5] = n[5] ^ fb;
            s = n;
            on = on + {12'd0, y};
        end
        sg = s;
    endtask

    int          nxt_x = 0;
    int          vec_cnt = 0;
    int          gap_err = 0;
    int          done_seen = 0;
    int          want_done = 0;
    logic [15:0] last_sig = 16'h0000;

    // Monitor: result check on done, x sequence tracking while busy.
    always @(negedge clk) begin
        if (m_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", cyc - start_cyc, e.done_cyc);
                chk("onset_count", {19'd0, m_onset}, {19'd0, e.onset});
                chk("signature", {16'd0, m_sig}, {16'd0, e.sig});
                chk("vector_count", vec_cnt, 4096);
                chk("vector_order_errors", gap_err, 0);
            end
            last_sig = m_sig;
            done_seen++;
        end
        if (!m_busy) begin
            nxt_x = 0;
            vec_cnt = 0;
            gap_err = 0;
        end
        if (m_xv) begin
            if ({20'd0, m_x} != nxt_x) gap_err++;
            nxt_x++;
            vec_cnt++;
        end
    end

    function automatic int lat_of(input int s);
        return (s == 1) ? 3 : ((s == 2) ? 2 : 0);
    endfunction

    task automatic run_sweep(input int s, input int fn, input int bubbles);
        exp_t e;
        logic [12:0] on;
        logic [15:0] sg;
        model(fn, on, sg);
        e.onset = on;
        e.sig = sg;
        e.done_cyc = 4097 + lat_of(s) + bubbles;
        sel = s;
        fn_sel = fn;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        want_done = done_seen + 1;
        start_cyc = cyc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_seen < want_done && n < 6000) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_done_timeout"}, (done_seen >= want_done) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_x(input logic [11:0] val);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 6000) begin
            @(posedge clk);
            #2;
            hit = m_xv && (m_x == val);
            n++;
        end
        chk("wait_x_timeout", {31'd0, hit}, 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_x"}, {20'd0, m_x}, 32'd0);
        chk({tag, "_x_valid"}, {31'd0, m_xv}, 32'd0);
        chk({tag, "_busy"}, {31'd0, m_busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, m_done}, 32'd0);
        chk({tag, "_onset"}, {19'd0, m_onset}, 32'd0);
        chk({tag, "_sig"}, {16'd0, m_sig}, 32'd0);
    endtask

    logic [15:0] sig_lat0;
    logic [12:0] on_ref;
    logic [15:0] sig_ref;
    int          poll;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        run_sweep(0, 0, 0); wait_done("lat0_zero");
        run_sweep(0, 1, 0); wait_done("lat0_x0");
        run_sweep(0, 2, 0); wait_done("lat0_one");
        run_sweep(0, 3, 0); wait_done("lat0_topF");
        sig_lat0 = last_sig;
        run_sweep(1, 3, 0); wait_done("lat3_topF");
        chk("lat3_vs_lat0_sig", {16'd0, last_sig}, {16'd0, sig_lat0});

        // LAT=2: 10 bubbles near vector 100, then holds during DRAIN.
        run_sweep(2, 1, 10);
        wait_x(12'd100);
        hold = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        hold = 1'b0;
        wait_x(12'd4095);
        @(posedge clk);
        #2;
        hold = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        hold = 1'b0;
        wait_done("lat2_hold");

        // Asynchronous reset mid-sweep, then a clean sweep.
        run_sweep(0, 1, 0);
        wait_x(12'd2000);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_sweep(0, 1, 0); wait_done("after_reset");

        // start pulses in RUN and in DONE must not restart.
        run_sweep(0, 1, 0);
        wait_x(12'd500);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        poll = 0;
        while (!m_done && poll < 6000) begin
            @(posedge clk);
            #2;
            poll++;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("start_pulses");
        repeat (20) @(posedge clk);
        #1;
        model(1, on_ref, sig_ref);
        chk("no_restart_busy", {31'd0, m_busy}, 32'd0);
        chk("no_restart_x_valid", {31'd0, m_xv}, 32'd0);
        chk("held_onset", {19'd0, m_onset}, {19'd0, on_ref});
        chk("held_sig", {16'd0, m_sig}, {16'd0, sig_ref});
        chk("leftover_expectations", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
